// File: rtl/pixie_dma_sequencer_pkg.sv
// Shared timing constants, widths and FSM encoding for the PIXIE DMA front end.
package pixie_dma_sequencer_pkg;

  localparam int CYCLES_PER_LINE    = 14;
  localparam int LINES_PER_FRAME    = 262;
  localparam int DISPLAY_START_LINE = 80;
  localparam int DISPLAY_LINES      = 128;
  localparam int BYTES_PER_LINE     = 8;
  localparam int DMA_START_CYCLE    = 2;
  localparam int INT_LEAD_LINES     = 2;
  localparam int EF_LEAD_LINES      = 4;
  localparam int DISPLAY_END_LINE   = DISPLAY_START_LINE + DISPLAY_LINES;

  localparam int FB_ADDR_W = 10;
  localparam int CYCLE_W   = 4;
  localparam int LINE_W    = 9;
  localparam int ROW_W     = 7;
  localparam int BYTE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dma_state_e;

  function automatic logic in_range(input logic [LINE_W-1:0] line, input int lo, input int hi);
    return (int'(line) >= lo) && (int'(line) <= hi);
  endfunction

endpackage

// File: rtl/pixie_line_timer.sv
// Machine-cycle and scan-line counters; both advance only on mc_tick.
// line_wrap/frame_wrap are combinational and flag the tick on which the counters wrap.
module pixie_line_timer
  import pixie_dma_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mc_tick,
  output logic [CYCLE_W-1:0] cycle,
  output logic [LINE_W-1:0]  line,
  output logic              line_wrap,
  output logic              frame_wrap
);

  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [LINE_W-1:0]  line_q, line_d;

  always_comb begin
    line_wrap  = mc_tick && (cycle_q == CYCLE_W'(CYCLES_PER_LINE - 1));
    frame_wrap = line_wrap && (line_q == LINE_W'(LINES_PER_FRAME - 1));
    cycle_d    = cycle_q;
    line_d     = line_q;
    if (mc_tick) begin
      cycle_d = line_wrap ? '0 : cycle_q + CYCLE_W'(1);
    end
    if (line_wrap) begin
      line_d = frame_wrap ? '0 : line_q + LINE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q <= '0;
      line_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      line_q  <= line_d;
    end
  end

  assign cycle = cycle_q;
  assign line  = line_q;

endmodule

// File: rtl/pixie_dma_sequencer.sv
// PIXIE CPU-side sequencer: INT/EF flags, per-line DMA-out request, framebuffer write port.
// Writes land 1 clk after the acknowledging mc_tick; the CPU throttles by withholding sc_dma.
module pixie_dma_sequencer
  import pixie_dma_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mc_tick,
  input  logic                 sc_dma,
  input  logic [7:0]           cpu_data,
  input  logic                 disp_on,
  input  logic                 disp_off,
  output logic                 int_n,
  output logic                 efx_n,
  output logic                 dma_out_n,
  output logic                 fb_write_en,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_data,
  output logic                 underrun
);

  logic [CYCLE_W-1:0] cycle;
  logic [LINE_W-1:0]  line;
  logic               line_wrap, frame_wrap;

  pixie_line_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .mc_tick    (mc_tick),
    .cycle      (cycle),
    .line       (line),
    .line_wrap  (line_wrap),
    .frame_wrap (frame_wrap)
  );

  dma_state_e           state_q, state_d;
  logic [BYTE_W-1:0]    byte_idx_q, byte_idx_d;
  logic                 disp_en_q, disp_en_d;
  logic                 frame_en_q, frame_en_d;
  logic                 int_n_q, int_n_d;
  logic                 efx_n_q, efx_n_d;
  logic                 dma_out_n_q, dma_out_n_d;
  logic                 fb_write_en_q, fb_write_en_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]           fb_data_q, fb_data_d;
  logic                 underrun_q, underrun_d;

  logic             in_window, ack, last_byte;
  logic [ROW_W-1:0] row;

  assign in_window = frame_en_q && in_range(line, DISPLAY_START_LINE, DISPLAY_END_LINE - 1);
  assign row       = ROW_W'(line - LINE_W'(DISPLAY_START_LINE));
  assign ack       = (state_q == ST_REQ) && mc_tick && sc_dma;
  assign last_byte = (byte_idx_q == BYTE_W'(BYTES_PER_LINE - 1));

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    dma_out_n_d   = dma_out_n_q;
    fb_write_en_d = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    underrun_d    = 1'b0;

    // Off wins a same-clk collision; frame_en only moves at the frame boundary.
    disp_en_d  = disp_off ? 1'b0 : (disp_on ? 1'b1 : disp_en_q);
    frame_en_d = frame_wrap ? disp_en_q : frame_en_q;

    int_n_d = !(frame_en_q &&
                in_range(line, DISPLAY_START_LINE - INT_LEAD_LINES, DISPLAY_START_LINE - 1));
    efx_n_d = !(frame_en_q &&
                (in_range(line, DISPLAY_START_LINE - EF_LEAD_LINES, DISPLAY_START_LINE - 1) ||
                 in_range(line, DISPLAY_END_LINE - EF_LEAD_LINES, DISPLAY_END_LINE - 1)));

    case (state_q)
      ST_IDLE: begin
        if (mc_tick && (cycle == CYCLE_W'(DMA_START_CYCLE - 1)) && in_window) begin
          state_d     = ST_REQ;
          dma_out_n_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (ack) begin
          fb_write_en_d = 1'b1;
          fb_addr_d     = {row, byte_idx_q};
          fb_data_d     = cpu_data;
          byte_idx_d    = byte_idx_q + BYTE_W'(1);
        end
        // A short line skips DONE: the wrap that ends it is the one DONE would wait for.
        if (line_wrap) begin
          state_d     = ST_IDLE;
          byte_idx_d  = '0;
          dma_out_n_d = 1'b1;
          underrun_d  = !(ack && last_byte);
        end else if (ack && last_byte) begin
          state_d     = ST_DONE;
          dma_out_n_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (line_wrap) begin
          state_d    = ST_IDLE;
          byte_idx_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      byte_idx_q    <= '0;
      disp_en_q     <= 1'b0;
      frame_en_q    <= 1'b0;
      int_n_q       <= 1'b1;
      efx_n_q       <= 1'b1;
      dma_out_n_q   <= 1'b1;
      fb_write_en_q <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      disp_en_q     <= disp_en_d;
      frame_en_q    <= frame_en_d;
      int_n_q       <= int_n_d;
      efx_n_q       <= efx_n_d;
      dma_out_n_q   <= dma_out_n_d;
      fb_write_en_q <= fb_write_en_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      underrun_q    <= underrun_d;
    end
  end

  assign int_n       = int_n_q;
  assign efx_n       = efx_n_q;
  assign dma_out_n   = dma_out_n_q;
  assign fb_write_en = fb_write_en_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign underrun    = underrun_q;

endmodule
